// File: rtl/div_nbit_nonrestore_pkg.sv
// Shared types and helpers for the calc/div non-restoring divider.
package div_pkg;

  // Controller states of the iterative divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Width of the iteration counter; it must hold DATA_WIDTH-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_nbit_step.sv
// One non-restoring division iteration: shift {P,Q} left, add or subtract
// the divisor depending on the sign of P, and append the new quotient bit.
module div_nbit_step #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH:0]   p_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH:0]   d_i,
  output logic [DATA_WIDTH:0]   p_o,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH:0] sh_s;

  // Shifted partial remainder, then subtract when P >= 0 or add when P < 0.
  always_comb begin
    sh_s = {p_i[DATA_WIDTH-1:0], q_i[DATA_WIDTH-1]};
    if (p_i[DATA_WIDTH] == 1'b0) begin
      p_o = sh_s - d_i;
    end else begin
      p_o = sh_s + d_i;
    end
    q_o = {q_i[DATA_WIDTH-2:0], ~p_o[DATA_WIDTH]};
  end

endmodule

// File: rtl/div_nbit_nonrestore.sv
// Sequential N-bit non-restoring divider (unsigned or two's complement).
// Works on magnitudes, one quotient bit per clock, one correction/sign
// cycle, then a DONE cycle whose exit edge publishes the results.
module div_nbit_nonrestore
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_dz
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [W-1:0] ONE_W = W'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    p_q, p_d;          // signed partial remainder / final remainder
  logic [W-1:0]  q_q, q_d;          // dividend magnitude shifting into quotient
  logic [W:0]    d_q, d_d;          // divisor magnitude
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          end_q, end_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          odz_q, odz_d;

  logic          x_neg_s, y_neg_s;
  logic [W-1:0]  x_mag_s, y_mag_s;
  logic [W:0]    p_step_s;
  logic [W-1:0]  q_step_s;
  logic [W:0]    p_fix_s;

  div_nbit_step #(.DATA_WIDTH(W)) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .d_i (d_q),
    .p_o (p_step_s),
    .q_o (q_step_s)
  );

  // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
  always_comb begin
    x_neg_s = i_signed & i_num_x[W-1];
    y_neg_s = i_signed & i_num_y[W-1];
    if (x_neg_s) begin
      x_mag_s = ~i_num_x + ONE_W;
    end else begin
      x_mag_s = i_num_x;
    end
    if (y_neg_s) begin
      y_mag_s = ~i_num_y + ONE_W;
    end else begin
      y_mag_s = i_num_y;
    end
  end

  // Final correction: a negative remainder gets the divisor added back.
  always_comb begin
    if (p_q[W]) begin
      p_fix_s = p_q + d_q;
    end else begin
      p_fix_s = p_q;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    end_d     = 1'b0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    odz_d     = odz_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          busy_d    = 1'b1;
          odz_d     = 1'b0;
          neg_quo_d = x_neg_s ^ y_neg_s;
          neg_rem_d = x_neg_s;
          d_d       = {1'b0, y_mag_s};
          if (i_num_y == '0) begin
            // Divide-by-zero skips the iterations entirely.
            dz_d    = 1'b1;
            q_d     = '1;
            p_d     = {1'b0, i_num_x};
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            q_d     = x_mag_s;
            p_d     = '0;
            cnt_d   = CW'(W - 1);
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = p_step_s;
        q_d   = q_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        if (neg_quo_q) begin
          q_d = ~q_q + ONE_W;
        end else begin
          q_d = q_q;
        end
        if (neg_rem_q) begin
          p_d = {1'b0, ~p_fix_s[W-1:0] + ONE_W};
        end else begin
          p_d = {1'b0, p_fix_s[W-1:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        end_d   = 1'b1;
        busy_d  = 1'b0;
        quo_d   = q_q;
        rem_d   = p_q[W-1:0];
        odz_d   = dz_q;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous dominant reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      odz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      odz_q     <= odz_d;
    end
  end

  assign o_busy = busy_q;
  assign o_end  = end_q;
  assign o_quo  = quo_q;
  assign o_rem  = rem_q;
  assign o_dz   = odz_q;

endmodule

// File: tb/tb_div_nbit_nonrestore.sv
// Scoreboard bench for div_nbit_nonrestore: directed cases plus exhaustive
// and random operands checked against an arithmetic reference model.
module tb_div_nbit_nonrestore;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         end_s;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dz;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
    int           end_edge;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit           chk_inv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;

  div_nbit_nonrestore #(.DATA_WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_signed (sgn),
    .i_num_x  (x),
    .i_num_y  (y),
    .o_busy   (busy),
    .o_end    (end_s),
    .o_quo    (quo),
    .o_rem    (rem),
    .o_dz     (dz)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows the dividend), results reduced to W bits.
  function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int xs, ys, qi, ri;
    e.x = a;
    e.y = b;
    e.end_edge = 0;
    e.chk_inv = (b != 0);
    if (b == 0) begin
      e.quo = '1;
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      xs = (s && a[W-1]) ? int'(a) - (1 << W) : int'(a);
      ys = (s && b[W-1]) ? int'(b) - (1 << W) : int'(b);
      qi = xs / ys;
      ri = xs % ys;
      e.quo = W'(qi);
      e.rem = W'(ri);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pop and compare on every o_end.
  always @(negedge clk) begin
    if (!rst && end_s) begin
      if (sb.size() == 0) begin
        check("spurious_end", int'(end_s), 0);
      end else begin
        mon_e = sb.pop_front();
        check("quo", int'(quo), int'(mon_e.quo));
        check("rem", int'(rem), int'(mon_e.rem));
        check("dz", int'(dz), int'(mon_e.dz));
        check("end_cycle", edge_cnt, mon_e.end_edge);
        check("busy_at_end", int'(busy), 0);
        if (mon_e.chk_inv)
          check("invariant", (int'(quo) * int'(mon_e.y) + int'(rem)) & ((1 << W) - 1), int'(mon_e.x));
      end
    end
  end

  task automatic issue_exp(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    @(negedge clk);
    sgn = s;
    x = a;
    y = b;
    start = 1'b1;
    e.end_edge = edge_cnt + 1 + ((b == 0) ? 1 : W + 2);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    sgn = 1'($urandom);
    x = W'($urandom);
    y = W'($urandom);
  endtask

  task automatic issue_model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_exp(s, a, b, model(s, a, b));
  endtask

  task automatic issue_dir(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    e.quo = eq;
    e.rem = er;
    e.dz = edz;
    e.end_edge = 0;
    e.x = a;
    e.y = b;
    e.chk_inv = (b != 0);
    issue_exp(s, a, b, e);
  endtask

  task automatic wait_done(input bit chk_busy);
    bit drop = 1'b0;
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
      if (!busy) drop = 1'b1;
      n++;
    end
    if (n >= 200) check("timeout_pending", sb.size(), 0);
    if (chk_busy) check("busy_held", int'(drop), 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rst_end;
    rst = 1'b1;
    start = 1'b0;
    sgn = 1'b0;
    x = '0;
    y = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_end", int'(end_s), 0);
    check("rst_quo", int'(quo), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_dz", int'(dz), 0);
    idle(2);
    rst = 1'b0;

    // 1: unsigned 10 / 9
    issue_dir(1'b0, 4'b1010, 4'b1001, 4'b0001, 4'b0001, 1'b0);
    wait_done(1'b1);
    // 2: signed -6/-7, then -6/5 issued the cycle after o_end
    issue_dir(1'b1, 4'b1010, 4'b1001, 4'b0000, 4'b1010, 1'b0);
    wait_done(1'b0);
    issue_dir(1'b1, 4'b1010, 4'b0101, 4'b1111, 4'b1111, 1'b0);
    wait_done(1'b0);
    // 3: divide by zero, then a normal op clears o_dz
    issue_dir(1'b0, 4'b0111, 4'b0000, 4'b1111, 4'b0111, 1'b1);
    wait_done(1'b0);
    issue_dir(1'b0, 4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0);
    wait_done(1'b0);
    // 4: signed overflow and 7 / -2
    issue_dir(1'b1, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
    wait_done(1'b0);
    issue_dir(1'b1, 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0);
    wait_done(1'b0);
    // 5: second start two cycles after the first is ignored
    issue_dir(1'b0, 4'b1101, 4'b0011, 4'b0100, 4'b0001, 1'b0);
    @(negedge clk);
    sgn = 1'b1;
    x = 4'b0110;
    y = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1);
    idle(W + 4);

    // 6: reset at E3 of a running op
    issue_dir(1'b0, 4'b1110, 4'b0011, 4'b0100, 4'b0010, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_end", int'(end_s), 0);
    check("midrst_quo", int'(quo), 0);
    check("midrst_rem", int'(rem), 0);
    check("midrst_dz", int'(dz), 0);
    idle(2);
    rst = 1'b0;
    rst_end = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (end_s) rst_end = 1'b1;
    end
    check("no_end_after_reset", int'(rst_end), 0);
    issue_dir(1'b0, 4'b1011, 4'b0010, 4'b0101, 4'b0001, 1'b0);
    wait_done(1'b0);

    // 7: every operand pair in both modes, random idle gaps
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          issue_model(1'(s), W'(a), W'(b));
          wait_done(1'b0);
          idle($urandom_range(0, 2));
        end
      end
    end
    // Extra random operations, sometimes back to back
    for (int k = 0; k < 100; k++) begin
      issue_model(1'($urandom), W'($urandom), W'($urandom));
      wait_done(1'b0);
      idle($urandom_range(0, 1));
    end

    idle(4);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_nbit_nonrestore.md
Name: div_nbit_nonrestore

Overview:
- Sequential iterative divider: N-bit dividend by N-bit divisor, producing N-bit quotient and N-bit remainder.
- Uses non-restoring division: one quotient bit per clock, then one sign-correction cycle.
- Inverse companion of the 2n-bit Booth multiplier in the calc library; lives under calc/div and uses the same operand/flag naming (num_x, num_y, end).
- Supports unsigned and two's-complement signed operation, selected per operation.

Parameters:
- DATA_WIDTH, 4, operand/quotient/remainder width in bits; legal range is 2 or more.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with i_start.
- i_num_x  in  DATA_WIDTH  dividend; captured with i_start.
- i_num_y  in  DATA_WIDTH  divisor; captured with i_start.
- o_busy  out  1  operation in progress.
- o_end  out  1  one-cycle pulse; results valid from this cycle on.
- o_quo  out  DATA_WIDTH  quotient.
- o_rem  out  DATA_WIDTH  remainder.
- o_dz  out  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset, asynchronous and dominant:
  - state = IDLE.
  - o_busy, o_end, o_dz = 0.
  - o_quo, o_rem = 0.
  - Internal registers cleared.
  - Reset mid-operation aborts the operation with no o_end.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On edge E0 with i_start = 1: capture operands and i_signed; o_dz cleared.
  - If divisor = 0, go to DONE; otherwise go to CALC with iteration counter = DATA_WIDTH - 1.
  - i_start is ignored in every other state (no queueing).
- Signed mode preprocessing:
  - Operate on magnitudes |x| and |y|, each DATA_WIDTH+1 bits wide so that the most negative value is handled.
  - Record sign_q = x_msb ^ y_msb and sign_r = x_msb.
- CALC, one iteration per edge:
  - Partial remainder P is DATA_WIDTH+1 bits signed.
  - Shift {P, Q} left by 1.
  - If P >= 0 then P = P - D, else P = P + D.
  - Q[0] = ~P_msb.
  - When the counter reaches 0, go to FIX; the counter decrements each edge.
- FIX, one edge:
  - If P < 0 then P = P + D.
  - Apply signs: quotient negated if sign_q; remainder negated if sign_r (signed mode only).
  - Go to DONE.
- DONE, one cycle:
  - o_end = 1; o_quo and o_rem updated.
  - Return to IDLE.
  - o_quo, o_rem and o_dz hold until the next operation's DONE.
- Latency, with the start-sampling edge as E0:
  - Normal operation: o_end is high in the cycle after edge E(DATA_WIDTH+2), i.e. cycle DATA_WIDTH+2, for exactly one cycle.
  - Divide-by-zero: o_end is high in the cycle after E1.
- o_busy is 1 from after E0 through the DONE cycle inclusive, and 0 in IDLE.
- i_start may be high during DONE without effect; it is accepted on the first IDLE edge, giving back-to-back issue one cycle after o_end.
- Arithmetic rules:
  - Signed quotient truncates toward zero; remainder takes the dividend's sign; invariant x = q*y + r.
  - Divide-by-zero: o_quo = all ones, o_rem = dividend unchanged, o_dz = 1.
  - Signed overflow (most negative / -1): o_quo = most negative (wraps), o_rem = 0, o_dz = 0.
- Operand inputs may change freely after E0 with no effect on the running operation.

Decomposition:
- Package div_pkg holds:
  - The state enum type (IDLE, CALC, FIX, DONE) with 2-bit encoding.
  - A counter-width function $clog2(DATA_WIDTH).
- Sub-module div_nbit_step: combinational single non-restoring iteration (shift, add/sub, quotient bit). The top holds the FSM, registers and sign handling.

Test Plan (DATA_WIDTH=4):
1. Unsigned: i_signed=0, x=4'b1010, y=4'b1001 -> o_quo=0001, o_rem=0001, o_dz=0. o_end high in the cycle after E6 (6 cycles after start), 1 cycle wide.
2. Signed, same operands (-6 / -7) -> o_quo=0000, o_rem=1010. Then signed x=1010, y=0101 (-6 / 5) issued the cycle after o_end -> o_quo=1111, o_rem=1111.
3. Divide-by-zero: x=0111, y=0000 -> o_quo=1111, o_rem=0111, o_dz=1, o_end in the cycle after E1. A following 0111 / 0010 unsigned -> q=0011, r=0001, o_dz=0.
4. Signed overflow: x=1000, y=1111 -> o_quo=1000, o_rem=0000, o_dz=0. Also signed 0111 / 1110 -> q=1101, r=0001.
5. Start while busy: second i_start pulse 2 cycles after the first with different operands -> ignored. Exactly one o_end, carrying the first operation's result; o_busy stays high continuously.
6. Reset mid-operation: assert i_rst at E3 of a normal op -> all outputs 0 immediately (asynchronous). No o_end. A new start after release completes correctly.
7. Exhaustive random check of all 4-bit pairs in both modes against the q*y + r invariant.
